// File: rtl/fmap_feeder_pkg.sv
// Shared definitions for the fmap feeder: FSM encoding and skid-buffer geometry.
package fmap_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ANNOUNCE = 2'd1,
        ST_STREAM   = 2'd2,
        ST_DRAIN    = 2'd3
    } fsm_state_e;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int SKID_PTR_W = $clog2(SKID_DEPTH);

endpackage

// File: rtl/fmap_skid_buf.sv
// Two-entry FIFO absorbing global-buffer read returns while the loader FIFO is full.
module fmap_skid_buf
    import fmap_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [SKID_CNT_W-1:0] count_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] rd_ptr_q;
    logic [SKID_PTR_W-1:0] wr_ptr_q;
    logic [SKID_CNT_W-1:0] cnt_q;
    logic                  push_ok;
    logic                  pop_ok;

    // A push into a full buffer is still accepted when the head leaves in the same cycle.
    assign push_ok = push_i && ((cnt_q != SKID_CNT_W'(SKID_DEPTH)) || pop_i);
    assign pop_ok  = pop_i && (cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + SKID_PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + SKID_PTR_W'(1);
            end
            cnt_q <= cnt_q + SKID_CNT_W'(push_ok) - SKID_CNT_W'(pop_ok);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fmap_feeder.sv
// Streams feature-map words from the global buffer into the per-PE loader FIFO,
// either a whole tile or one column at a time from an internally tracked column pointer.
module fmap_feeder
    import fmap_feeder_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int ADDRESSWIDTH_F_PAD = 8,
    parameter int GB_ADDR_WIDTH      = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          send_start,
    input  logic                          send_full_column,
    input  logic [ADDRESSWIDTH_F_PAD-1:0] pixel_num,
    input  logic [ADDRESSWIDTH_F_PAD-1:0] load_one_cloumn_num,
    input  logic [GB_ADDR_WIDTH-1:0]      gb_base_addr,
    output logic                          gb_ren,
    output logic [GB_ADDR_WIDTH-1:0]      gb_raddr,
    input  logic [DATA_WIDTH-1:0]         gb_rdata,
    input  logic                          fifo_full,
    output logic [DATA_WIDTH-1:0]         fmap_in,
    output logic                          fmap_in_en,
    output logic                          fmap_load_start,
    output logic                          load_full_cloumn,
    output logic                          busy,
    output logic                          send_done
);

    localparam int AW = ADDRESSWIDTH_F_PAD;
    localparam int OW = SKID_CNT_W + 1;

    fsm_state_e               state_q, state_d;
    logic [AW-1:0]            count_q, count_d;
    logic [AW-1:0]            issued_q, issued_d;
    logic [AW-1:0]            sent_q, sent_d;
    logic [AW-1:0]            col_ptr_q, col_ptr_d;
    logic [GB_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                     mode_q, mode_d;
    logic                     inflight_q;

    logic                     issue;
    logic                     pop;
    logic [OW-1:0]            occ_eff;
    logic [AW:0]              col_sum;
    logic [SKID_CNT_W-1:0]    skid_count;
    logic                     skid_empty;
    logic [DATA_WIDTH-1:0]    skid_head;

    fmap_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (gb_rdata),
        .pop_i       (pop),
        .head_o      (skid_head),
        .count_o     (skid_count),
        .empty_o     (skid_empty)
    );

    assign pop = ((state_q == ST_STREAM) || (state_q == ST_DRAIN)) && !skid_empty && !fifo_full;

    // The head leaving this cycle frees its slot, which keeps the stream at one word per cycle.
    assign occ_eff = OW'(skid_count) + OW'(inflight_q) - OW'(pop);
    assign issue   = (state_q == ST_STREAM) && (issued_q < count_q) && (occ_eff < OW'(SKID_DEPTH));

    assign col_sum = {1'b0, col_ptr_q} + {1'b0, load_one_cloumn_num};

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        issued_d        = issued_q;
        sent_d          = sent_q;
        rd_addr_d       = rd_addr_q;
        col_ptr_d       = col_ptr_q;
        mode_d          = mode_q;
        fmap_load_start = 1'b0;
        send_done       = 1'b0;

        if (issue) begin
            issued_d  = issued_q + AW'(1);
            rd_addr_d = rd_addr_q + GB_ADDR_WIDTH'(1);
        end
        if (pop) begin
            sent_d = sent_q + AW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (send_start) begin
                    mode_d   = send_full_column;
                    issued_d = '0;
                    sent_d   = '0;
                    if (send_full_column) begin
                        count_d   = pixel_num;
                        rd_addr_d = gb_base_addr;
                        col_ptr_d = '0;
                    end else begin
                        count_d   = load_one_cloumn_num;
                        rd_addr_d = gb_base_addr + GB_ADDR_WIDTH'(col_ptr_q);
                    end
                    state_d = ST_ANNOUNCE;
                end
            end
            ST_ANNOUNCE: begin
                fmap_load_start = 1'b1;
                state_d         = (count_q == '0) ? ST_DRAIN : ST_STREAM;
            end
            ST_STREAM: begin
                if (issued_d == count_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((sent_q == count_q) && !inflight_q) begin
                    send_done = 1'b1;
                    state_d   = ST_IDLE;
                    if (!mode_q) begin
                        col_ptr_d = (col_sum >= {1'b0, pixel_num}) ? '0 : col_sum[AW-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            issued_q   <= '0;
            sent_q     <= '0;
            col_ptr_q  <= '0;
            rd_addr_q  <= '0;
            mode_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            col_ptr_q  <= col_ptr_d;
            rd_addr_q  <= rd_addr_d;
            mode_q     <= mode_d;
            inflight_q <= issue;
        end
    end

    assign gb_ren           = issue;
    assign gb_raddr         = issue ? rd_addr_q : '0;
    assign fmap_in_en       = pop;
    assign fmap_in          = pop ? skid_head : '0;
    assign load_full_cloumn = mode_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fmap_feeder.sv
// Directed and randomized transfers checked against an address/word model of the feeder.
module tb_fmap_feeder;

    logic        clk;
    logic        rst_n;
    logic        send_start;
    logic        send_full_column;
    logic [7:0]  pixel_num;
    logic [7:0]  load_one_cloumn_num;
    logic [11:0] gb_base_addr;
    logic        gb_ren;
    logic [11:0] gb_raddr;
    logic [15:0] gb_rdata;
    logic        fifo_full;
    logic [15:0] fmap_in;
    logic        fmap_in_en;
    logic        fmap_load_start;
    logic        load_full_cloumn;
    logic        busy;
    logic        send_done;

    fmap_feeder #(
        .DATA_WIDTH         (16),
        .ADDRESSWIDTH_F_PAD (8),
        .GB_ADDR_WIDTH      (12)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .send_start          (send_start),
        .send_full_column    (send_full_column),
        .pixel_num           (pixel_num),
        .load_one_cloumn_num (load_one_cloumn_num),
        .gb_base_addr        (gb_base_addr),
        .gb_ren              (gb_ren),
        .gb_raddr            (gb_raddr),
        .gb_rdata            (gb_rdata),
        .fifo_full           (fifo_full),
        .fmap_in             (fmap_in),
        .fmap_in_en          (fmap_in_en),
        .fmap_load_start     (fmap_load_start),
        .load_full_cloumn    (load_full_cloumn),
        .busy                (busy),
        .send_done           (send_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] gb_mem [4096];
    always @(posedge clk) begin
        if (gb_ren) gb_rdata <= gb_mem[gb_raddr];
    end

    int checks = 0;
    int errors = 0;
    int col_model = 0;
    logic exp_mode = 1'b0;

    int cyc = 0;
    logic [11:0] raddr_q[$];
    logic [15:0] words_q[$];
    int iss_tot, wr_tot, bp_viol, out_viol, lfc_viol;
    int start_cyc, done_cyc, done_cnt, first_en, last_en, first_ren, last_ren;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (gb_ren) begin
            raddr_q.push_back(gb_raddr);
            iss_tot <= iss_tot + 1;
            if (first_ren < 0) first_ren <= cyc;
            last_ren <= cyc;
        end
        if (fmap_in_en) begin
            words_q.push_back(fmap_in);
            wr_tot <= wr_tot + 1;
            if (fifo_full) bp_viol <= bp_viol + 1;
            if (first_en < 0) first_en <= cyc;
            last_en <= cyc;
        end
        if ((iss_tot + int'(gb_ren)) - (wr_tot + int'(fmap_in_en)) > 2) out_viol <= out_viol + 1;
        if (busy && (load_full_cloumn !== exp_mode)) lfc_viol <= lfc_viol + 1;
        if (fmap_load_start) start_cyc <= cyc;
        if (send_done) begin
            done_cyc <= cyc;
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        raddr_q.delete();
        words_q.delete();
        iss_tot = 0; wr_tot = 0; bp_viol = 0; out_viol = 0; lfc_viol = 0;
        start_cyc = -1; done_cyc = -1; done_cnt = 0;
        first_en = -1; last_en = -1; first_ren = -1; last_ren = -1;
    endtask

    // bp: 0 = FIFO never full, 1 = hold then alternate, 2 = random. poke: extra send_start mid-stream.
    task automatic run_xfer(input bit full, input logic [7:0] pix, input logic [7:0] lc,
                            input logic [11:0] base, input int bp, input bit poke);
        int n;
        int s;
        int j;
        logic [11:0] exp_base;
        n        = full ? int'(pix) : int'(lc);
        exp_base = base + (full ? 12'd0 : 12'(col_model));
        if (full) col_model = 0;
        clear_obs();
        pixel_num           = pix;
        load_one_cloumn_num = lc;
        gb_base_addr        = base;
        send_full_column    = full;
        exp_mode            = full;
        fifo_full           = 1'b0;
        send_start          = 1'b1;
        @(posedge clk);
        s = cyc;
        #1;
        send_start = 1'b0;
        j = 1;
        while (done_cnt == 0 && j < 300) begin
            case (bp)
                1:       fifo_full = (j >= 3 && j <= 7) ? 1'b1 : ((j > 7) ? j[0] : 1'b0);
                2:       fifo_full = 1'($urandom_range(0, 1));
                default: fifo_full = 1'b0;
            endcase
            send_start       = poke && (j == 3);
            send_full_column = poke ? ~full : full;
            @(posedge clk);
            #1;
            j++;
        end
        send_start       = 1'b0;
        send_full_column = full;
        fifo_full        = 1'b0;
        chk("done_count", done_cnt, 1);
        chk("busy_after_done", busy, 1'b0);
        chk("lfc_hold", load_full_cloumn, full);
        chk("start_pulse_cycle", start_cyc, s);
        chk("ren_count", raddr_q.size(), n);
        chk("word_count", words_q.size(), n);
        for (int i = 0; i < n && i < raddr_q.size(); i++)
            chk($sformatf("raddr[%0d]", i), raddr_q[i], exp_base + 12'(i));
        for (int i = 0; i < n && i < words_q.size(); i++)
            chk($sformatf("word[%0d]", i), words_q[i], gb_mem[exp_base + 12'(i)]);
        chk("no_write_while_full", bp_viol, 0);
        chk("outstanding_le_2", out_viol, 0);
        chk("lfc_during_xfer", lfc_viol, 0);
        if (n == 0) begin
            chk("zero_done_after_announce", done_cyc, s + 1);
        end else begin
            chk("done_after_last_write", done_cyc, last_en + 1);
            if (bp == 0) begin
                // send_start sampled at edge 0: ANNOUNCE, issue, return, then first write
                chk("first_write_latency", first_en, s + 3);
                chk("reads_back_to_back", last_ren - first_ren, n - 1);
                chk("writes_back_to_back", last_en - first_en, n - 1);
            end
        end
        if (!full) col_model = (col_model + int'(lc) >= int'(pix)) ? 0 : col_model + int'(lc);
        $display("xfer full=%0d pix=%0d lc=%0d base=%03h bp=%0d words=%0d checks=%0d errors=%0d",
                 full, pix, lc, base, bp, words_q.size(), checks, errors);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) gb_mem[i] = 16'($urandom);
        rst_n = 1'b0; send_start = 1'b0; send_full_column = 1'b0; pixel_num = '0;
        load_one_cloumn_num = '0; gb_base_addr = '0; fifo_full = 1'b0; gb_rdata = '0;
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_strobes", {gb_ren, fmap_in_en, fmap_load_start, send_done, busy, load_full_cloumn}, 6'b0);
        chk("reset_raddr", gb_raddr, 12'h000);
        chk("reset_fmap_in", fmap_in, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_xfer(1'b1, 8'd8, 8'd0, 12'h100, 0, 1'b0);
        for (int k = 0; k < 4; k++) run_xfer(1'b0, 8'd9, 8'd3, 12'h200, 0, 1'b0);
        run_xfer(1'b0, 8'd9, 8'd0, 12'h200, 0, 1'b0);
        run_xfer(1'b0, 8'd9, 8'd3, 12'h200, 0, 1'b0);
        run_xfer(1'b1, 8'd6, 8'd0, 12'h300, 1, 1'b0);
        run_xfer(1'b1, 8'd6, 8'd0, 12'h340, 0, 1'b1);
        run_xfer(1'b0, 8'd12, 8'd4, 12'h400, 0, 1'b0);

        clear_obs();
        pixel_num = 8'd12; load_one_cloumn_num = 8'd4; gb_base_addr = 12'h400;
        send_full_column = 1'b0; exp_mode = 1'b0; fifo_full = 1'b1; send_start = 1'b1;
        @(posedge clk);
        #1;
        send_start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_reads_buffered", iss_tot, 2);
        chk("midrst_first_addr", raddr_q.size() > 0 ? raddr_q[0] : 12'hfff, 12'h404);
        chk("midrst_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_strobes", {gb_ren, fmap_in_en, fmap_load_start, send_done, busy, load_full_cloumn}, 6'b0);
        chk("midrst_raddr", gb_raddr, 12'h000);
        chk("midrst_fmap_in", fmap_in, 16'h0000);
        $display("midstream reset checks=%0d errors=%0d", checks, errors);
        col_model = 0;
        fifo_full = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_xfer(1'b0, 8'd12, 8'd4, 12'h400, 0, 1'b0);

        for (int k = 0; k < 8; k++)
            run_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(1, 16)), 8'($urandom_range(0, 6)),
                     12'($urandom), 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
